// File: rtl/pc_fetch_stage.sv
// Program counter and single-outstanding instruction fetch controller.
// Presents {pc, pc+1, instr} to decode under valid/ready; later stages may redirect.
module pc_fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [31:0]       imem_resp_data,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc_next,
    output logic [31:0]       if_instr,
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_FULL  = 2'd3
    } state_e;

    // Handshakes: a transfer happens in any cycle where valid and ready are both
    // high at the rising clock edge; valid and its payload stay stable until then.
    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic              drop_q;
    logic              if_valid_q;
    logic [ADDR_W-1:0] if_pc_q;
    logic [ADDR_W-1:0] if_pc_next_q;
    logic [31:0]       if_instr_q;
    logic [ADDR_W-1:0] pc_inc_d;

    assign pc_inc_d = pc_q + ADDR_W'(1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            drop_q       <= 1'b0;
            if_valid_q   <= 1'b0;
            if_pc_q      <= RESET_PC;
            if_pc_next_q <= RESET_PC + ADDR_W'(1);
            if_instr_q   <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_pc;
                    end
                    state_q <= S_FETCH;
                end
                S_FETCH: begin
                    if (redirect_valid) begin
                        pc_q       <= redirect_pc;
                        if_valid_q <= 1'b0;
                        // Request to the old pc already left: its response must be dropped.
                        if (imem_req_ready) begin
                            drop_q  <= 1'b1;
                            state_q <= S_WAIT;
                        end
                    end else if (imem_req_ready) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) begin
                        pc_q       <= redirect_pc;
                        if_valid_q <= 1'b0;
                        if (imem_resp_valid) begin
                            drop_q  <= 1'b0;
                            state_q <= S_FETCH;
                        end else begin
                            drop_q <= 1'b1;
                        end
                    end else if (imem_resp_valid) begin
                        if (drop_q) begin
                            drop_q  <= 1'b0;
                            state_q <= S_FETCH;
                        end else begin
                            if_instr_q   <= imem_resp_data;
                            if_pc_q      <= pc_q;
                            if_pc_next_q <= pc_inc_d;
                            if_valid_q   <= 1'b1;
                            pc_q         <= pc_inc_d;
                            state_q      <= S_FULL;
                        end
                    end
                end
                S_FULL: begin
                    if (redirect_valid) begin
                        pc_q       <= redirect_pc;
                        if_valid_q <= 1'b0;
                        state_q    <= S_FETCH;
                    end else if (if_ready) begin
                        if_valid_q <= 1'b0;
                        state_q    <= S_FETCH;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign imem_req_valid = (state_q == S_FETCH);
    assign imem_req_addr  = pc_q;
    assign if_valid       = if_valid_q;
    assign if_pc          = if_pc_q;
    assign if_pc_next     = if_pc_next_q;
    assign if_instr       = if_instr_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Bench for pc_fetch_stage: directed vector table, hand-written reset/wrap sequences,
// and a randomized run checked against a transaction-level fetch-order model.
module tb_pc_fetch_stage;

    logic        clock;
    logic        reset_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        if_ready;

    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pc_next;
    logic [31:0] if_instr;
    logic [1:0]  dbg_state;

    logic        w_req_valid;
    logic [31:0] w_req_addr;
    logic        w_if_valid;
    logic [31:0] w_if_pc;
    logic [31:0] w_if_pc_next;
    logic [31:0] w_if_instr;
    logic [1:0]  w_dbg_state;

    int checks = 0;
    int failures = 0;

    pc_fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
        .clock(clock), .reset_n(reset_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
        .if_pc_next(if_pc_next), .if_instr(if_instr), .dbg_state_o(dbg_state)
    );

    // Same stimulus as dut; only its wrap-around behaviour is checked.
    pc_fetch_stage #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFF)) dut_wrap (
        .clock(clock), .reset_n(reset_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(w_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(w_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .if_valid(w_if_valid), .if_ready(if_ready), .if_pc(w_if_pc),
        .if_pc_next(w_if_pc_next), .if_instr(w_if_instr), .dbg_state_o(w_dbg_state)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_A5A5;
    endfunction

    typedef struct {
        logic        red_v;
        logic [31:0] red_pc;
        logic        req_rdy;
        logic        resp_v;
        logic [31:0] resp_d;
        logic        if_rdy;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rv, input logic [31:0] rpc, input logic rr,
                       input logic sv, input logic [31:0] sd, input logic ir,
                       input logic e_rv, input logic [31:0] e_addr, input logic e_iv,
                       input logic [31:0] e_pc, input logic [31:0] e_instr);
        vec_t v;
        v.red_v = rv; v.red_pc = rpc; v.req_rdy = rr; v.resp_v = sv; v.resp_d = sd;
        v.if_rdy = ir; v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv;
        v.e_pc = e_pc; v.e_instr = e_instr;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rv, input logic [31:0] rpc, input logic rr,
                         input logic sv, input logic [31:0] sd, input logic ir);
        redirect_valid  = rv;
        redirect_pc     = rpc;
        imem_req_ready  = rr;
        imem_resp_valid = sv;
        imem_resp_data  = sd;
        if_ready        = ir;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic check_out(input string name, input logic e_rv, input logic [31:0] e_addr,
                             input logic e_iv, input logic [31:0] e_pc,
                             input logic [31:0] e_pcn, input logic [31:0] e_instr);
        checks++;
        if (imem_req_valid !== e_rv || imem_req_addr !== e_addr || if_valid !== e_iv ||
            if_pc !== e_pc || if_pc_next !== e_pcn || if_instr !== e_instr) begin
            failures++;
            $display("FAIL %s: got req_v=%0b addr=%h if_v=%0b pc=%h pcn=%h instr=%h; want req_v=%0b addr=%h if_v=%0b pc=%h pcn=%h instr=%h",
                     name, imem_req_valid, imem_req_addr, if_valid, if_pc, if_pc_next, if_instr,
                     e_rv, e_addr, e_iv, e_pc, e_pcn, e_instr);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_out("reset_values", 0, 32'h0, 0, 32'h0, 32'h1, 32'h0);
        check_val("wrap_reset_pc", w_if_pc, 32'hFFFF_FFFF);
        check_val("wrap_reset_pcn", w_if_pc_next, 32'h0);
        reset_n = 1'b1;
    endtask

    // Random-phase model state
    logic [31:0] req_q[$];
    logic [31:0] exp_pc;
    int          resp_delay;
    int          deliveries;
    logic        p_valid, p_rv, p_rr, p_iv, p_ir, p_red;
    logic [31:0] p_addr, p_pc, p_pcn, p_instr;

    initial begin
        logic [31:0] lp, li;
        reset_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0);

        // Free-running fetch of 0..4, backpressure at 4, redirect in FULL and in WAIT.
        add(0, 0, 1, 0, 0, 0, 1, 32'h0, 0, 32'h0, 32'h0);
        lp = 32'h0; li = 32'h0;
        for (int k = 0; k < 5; k++) begin
            add(0, 0, 1, 0, 0, 0, 0, k, 0, lp, li);
            add(0, 0, 1, 1, mem_word(k), 0, 0, k + 1, 1, k, mem_word(k));
            lp = k; li = mem_word(k);
            if (k < 4) add(0, 0, 1, 0, 0, 1, 1, k + 1, 0, lp, li);
        end
        for (int k = 0; k < 5; k++) add(0, 0, 1, 0, 0, 0, 0, 32'h5, 1, 32'h4, mem_word(4));
        add(0, 0, 1, 0, 0, 1, 1, 32'h5, 0, 32'h4, mem_word(4));
        add(0, 0, 1, 0, 0, 0, 0, 32'h5, 0, 32'h4, mem_word(4));
        add(0, 0, 1, 1, mem_word(5), 0, 0, 32'h6, 1, 32'h5, mem_word(5));
        add(1, 32'h8, 1, 0, 0, 1, 1, 32'h8, 0, 32'h5, mem_word(5));
        add(0, 0, 1, 0, 0, 0, 0, 32'h8, 0, 32'h5, mem_word(5));
        add(1, 32'h40, 1, 0, 0, 0, 0, 32'h40, 0, 32'h5, mem_word(5));
        add(0, 0, 1, 0, 0, 0, 0, 32'h40, 0, 32'h5, mem_word(5));
        add(0, 0, 1, 1, mem_word(8), 0, 1, 32'h40, 0, 32'h5, mem_word(5));
        add(0, 0, 1, 0, 0, 0, 0, 32'h40, 0, 32'h5, mem_word(5));
        add(0, 0, 1, 1, mem_word(32'h40), 0, 0, 32'h41, 1, 32'h40, mem_word(32'h40));
        add(0, 0, 1, 0, 0, 1, 1, 32'h41, 0, 32'h40, mem_word(32'h40));

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].red_v, vecs[i].red_pc, vecs[i].req_rdy, vecs[i].resp_v,
                  vecs[i].resp_d, vecs[i].if_rdy);
            next_cycle();
            check_out($sformatf("vec%0d", i), vecs[i].e_rv, vecs[i].e_addr, vecs[i].e_iv,
                      vecs[i].e_pc, vecs[i].e_pc + 32'd1, vecs[i].e_instr);
            if (i == 2) begin
                check_val("wrap_first_pc", w_if_pc, 32'hFFFF_FFFF);
                check_val("wrap_first_pcn", w_if_pc_next, 32'h0);
            end
            if (i == 3) begin
                check_val("wrap_second_req_v", {31'd0, w_req_valid}, 32'h1);
                check_val("wrap_second_req_addr", w_req_addr, 32'h0);
            end
        end

        // Asynchronous reset while a request is outstanding.
        drive(0, 0, 1, 0, 0, 0);
        next_cycle();
        check_out("wait_before_reset", 0, 32'h41, 0, 32'h40, 32'h41, mem_word(32'h40));
        drive(0, 0, 0, 0, 0, 0);
        #2 reset_n = 1'b0;
        #1 check_out("async_reset_now", 0, 32'h0, 0, 32'h0, 32'h1, 32'h0);
        drive(0, 0, 0, 1, mem_word(32'h41), 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        next_cycle();
        check_out("post_reset_fetch", 1, 32'h0, 0, 32'h0, 32'h1, 32'h0);
        next_cycle();
        check_out("stale_resp_ignored", 1, 32'h0, 0, 32'h0, 32'h1, 32'h0);
        drive(0, 0, 1, 0, 0, 0);
        next_cycle();
        check_out("post_reset_wait", 0, 32'h0, 0, 32'h0, 32'h1, 32'h0);
        drive(0, 0, 1, 1, mem_word(32'h0), 0);
        next_cycle();
        check_out("post_reset_full", 0, 32'h1, 1, 32'h0, 32'h1, mem_word(32'h0));

        // Randomized run: delivered instructions must follow the architectural
        // fetch order (sequential, restarted at each redirect target).
        do_reset();
        exp_pc = 32'h0;
        deliveries = 0;
        resp_delay = 0;
        p_valid = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic rv, rr, sv, ir;
            logic [31:0] rpc, sd;
            if (p_valid) begin
                if (p_rv && !p_rr && !p_red) begin
                    checks++;
                    if (!imem_req_valid || imem_req_addr !== p_addr) begin
                        failures++;
                        $display("FAIL req_hold cyc=%0d: got v=%0b addr=%h want v=1 addr=%h",
                                 cyc, imem_req_valid, imem_req_addr, p_addr);
                    end
                end
                if (p_iv && !p_ir && !p_red) begin
                    checks++;
                    if (!if_valid || if_pc !== p_pc || if_pc_next !== p_pcn || if_instr !== p_instr) begin
                        failures++;
                        $display("FAIL if_hold cyc=%0d: got v=%0b pc=%h pcn=%h instr=%h want v=1 pc=%h pcn=%h instr=%h",
                                 cyc, if_valid, if_pc, if_pc_next, if_instr, p_pc, p_pcn, p_instr);
                    end
                end
                if (p_iv && (p_ir || p_red)) check_val($sformatf("if_clear cyc=%0d", cyc),
                                                       {31'd0, if_valid}, 32'h0);
            end
            check_val($sformatf("one_outstanding cyc=%0d", cyc),
                      {31'd0, imem_req_valid && (req_q.size() != 0)}, 32'h0);

            rv = ($urandom_range(0, 11) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - $urandom_range(0, 3))
                                              : $urandom_range(0, 16'hFFFF);
            rr = ($urandom_range(0, 9) < 7);
            ir = ($urandom_range(0, 9) < 7);
            sv = 1'b0;
            sd = $urandom;
            if (req_q.size() != 0) begin
                if (resp_delay == 0) begin
                    sv = 1'b1;
                    sd = mem_word(req_q[0]);
                end else begin
                    resp_delay--;
                end
            end else begin
                sv = ($urandom_range(0, 4) == 0);
            end
            drive(rv, rpc, rr, sv, sd, ir);

            if (if_valid && ir && !rv) begin
                checks++;
                if (if_pc !== exp_pc || if_pc_next !== exp_pc + 32'd1 || if_instr !== mem_word(exp_pc)) begin
                    failures++;
                    $display("FAIL deliver cyc=%0d: got pc=%h pcn=%h instr=%h want pc=%h pcn=%h instr=%h",
                             cyc, if_pc, if_pc_next, if_instr, exp_pc, exp_pc + 32'd1, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 32'd1;
                deliveries++;
            end
            if (rv) exp_pc = rpc;
            if (sv && req_q.size() != 0) void'(req_q.pop_front());
            if (imem_req_valid && rr) begin
                req_q.push_back(imem_req_addr);
                resp_delay = $urandom_range(0, 2);
            end

            p_valid = 1'b1;
            p_rv = imem_req_valid; p_rr = rr; p_addr = imem_req_addr;
            p_iv = if_valid; p_ir = ir; p_red = rv;
            p_pc = if_pc; p_pcn = if_pc_next; p_instr = if_instr;
            next_cycle();
        end
        checks++;
        if (deliveries < 50) begin
            failures++;
            $display("FAIL progress: got %0d deliveries want at least 50", deliveries);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
